// File: rtl/qspi_pkg.sv
// Shared opcodes and FSM state encoding for the QSPI flash responder.
package qspi_pkg;

    localparam logic [7:0] CMD_READ3B  = 8'h03;
    localparam logic [7:0] CMD_READ4B  = 8'h13;
    localparam logic [7:0] CMD_QREAD3B = 8'hEB;
    localparam logic [7:0] CMD_QREAD4B = 8'hEC;
    localparam logic [7:0] CMD_PP      = 8'h02;
    localparam logic [7:0] CMD_QPP     = 8'h32;
    localparam logic [7:0] CMD_EN4B    = 8'hB7;
    localparam logic [7:0] CMD_EX4B    = 8'hE9;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/qspi_resp_shifter.sv
// 32-bit load/shift register, shifting 1 or 4 bits per edge MSB first.
module qspi_resp_shifter (
    input  logic        sclk,
    input  logic        h_rstn,
    input  logic        ld,
    input  logic        sh,
    input  logic        quad,
    input  logic [31:0] din,
    input  logic [3:0]  sin,
    output logic [3:0]  msn,
    output logic [31:0] nxt
);

    logic [31:0] q;

    assign nxt = quad ? {q[27:0], sin} : {q[30:0], sin[0]};
    assign msn = q[31:28];

    always_ff @(posedge sclk or negedge h_rstn) begin
        if (!h_rstn) begin
            q <= '0;
        end else if (ld) begin
            q <= din;
        end else if (sh) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI flash-side responder: command/address/dummy decode, read streaming and program assembly.
//   state      | meaning
//   ST_CMD     | collecting 8 opcode bits on io0
//   ST_ADDR    | collecting address (io0, or io3..io0 for quad reads)
//   ST_DUMMY   | quad-read dummy cycles, first word loads on the last one
//   ST_RD_DATA | shifting read words out, prefetching the next word
//   ST_WR_DATA | assembling program words, one write per word
//   ST_IGNORE  | mode command done or unknown opcode, wait for deselect
module qspi_flash_responder
    import qspi_pkg::*;
#(
    parameter int DUMMY_CYCLES = 4,
    parameter bit ADDR4B_RST   = 1'b0
) (
    input  logic        sclk,
    input  logic        h_rstn,
    input  logic        cs_n,
    input  logic [3:0]  io_in,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic        addr_4b_mode,
    output logic        busy,
    output logic        cmd_err
);

    localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_CYCLES - 1);

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        xfer_quad, xfer_quad_nxt, xfer_wr, xfer_wr_nxt;
    logic        mode_nxt, rd_en_nxt, wr_en_nxt, err_nxt, ld_word;
    logic [3:0]  oe_reg, oe_nxt, sh_msn;
    logic [31:0] addr_nxt, wdata_nxt, rd_buf, sh_din, sh_next;
    logic        sh_ld, sh_sh, sh_quad;

    qspi_resp_shifter u_shifter (
        .sclk   (sclk),
        .h_rstn (h_rstn),
        .ld     (sh_ld),
        .sh     (sh_sh),
        .quad   (sh_quad),
        .din    (sh_din),
        .sin    (io_in),
        .msn    (sh_msn),
        .nxt    (sh_next)
    );

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        xfer_quad_nxt = xfer_quad;
        xfer_wr_nxt   = xfer_wr;
        mode_nxt      = addr_4b_mode;
        oe_nxt        = oe_reg;
        rd_en_nxt     = 1'b0;
        wr_en_nxt     = 1'b0;
        err_nxt       = 1'b0;
        ld_word       = 1'b0;
        addr_nxt      = mem_wr_en ? mem_addr + 32'd4 : mem_addr;
        wdata_nxt     = mem_wdata;
        sh_ld         = 1'b0;
        sh_sh         = 1'b0;
        sh_quad       = xfer_quad;
        // A word requested last cycle is still on mem_rdata; older ones sit in rd_buf.
        sh_din        = mem_rd_en ? mem_rdata : rd_buf;

        if (cs_n) begin
            state_nxt = ST_CMD;
            cnt_nxt   = 6'd7;
            oe_nxt    = 4'h0;
        end else begin
            case (state)
                ST_CMD: begin
                    sh_quad = 1'b0;
                    sh_sh   = 1'b1;
                    if (cnt == 6'd0) begin
                        sh_ld     = 1'b1;
                        sh_din    = '0;
                        state_nxt = ST_ADDR;
                        cnt_nxt   = addr_4b_mode ? 6'd31 : 6'd23;
                        case (sh_next[7:0])
                            CMD_READ3B:  {xfer_quad_nxt, xfer_wr_nxt} = 2'b00;
                            CMD_READ4B: begin
                                {xfer_quad_nxt, xfer_wr_nxt} = 2'b00;
                                cnt_nxt = 6'd31;
                            end
                            CMD_QREAD3B: begin
                                {xfer_quad_nxt, xfer_wr_nxt} = 2'b10;
                                cnt_nxt = addr_4b_mode ? 6'd7 : 6'd5;
                            end
                            CMD_QREAD4B: begin
                                {xfer_quad_nxt, xfer_wr_nxt} = 2'b10;
                                cnt_nxt = 6'd7;
                            end
                            CMD_PP:      {xfer_quad_nxt, xfer_wr_nxt} = 2'b01;
                            CMD_QPP:     {xfer_quad_nxt, xfer_wr_nxt} = 2'b11;
                            CMD_EN4B: begin
                                mode_nxt  = 1'b1;
                                state_nxt = ST_IGNORE;
                            end
                            CMD_EX4B: begin
                                mode_nxt  = 1'b0;
                                state_nxt = ST_IGNORE;
                            end
                            default: begin
                                err_nxt   = 1'b1;
                                state_nxt = ST_IGNORE;
                            end
                        endcase
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                    end
                end
                ST_ADDR: begin
                    sh_quad = xfer_quad & ~xfer_wr;
                    sh_sh   = 1'b1;
                    if (cnt == 6'd0) begin
                        addr_nxt = {sh_next[31:2], 2'b00};
                        if (xfer_wr) begin
                            state_nxt = ST_WR_DATA;
                            cnt_nxt   = xfer_quad ? 6'd7 : 6'd31;
                        end else begin
                            rd_en_nxt = 1'b1;
                            state_nxt = xfer_quad ? ST_DUMMY : ST_RD_DATA;
                            cnt_nxt   = xfer_quad ? DUMMY_LAST : 6'd0;
                        end
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                    end
                end
                ST_DUMMY: begin
                    if (cnt == 6'd0) begin
                        state_nxt = ST_RD_DATA;
                        ld_word   = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                    end
                end
                ST_RD_DATA: begin
                    if (cnt == 6'd0) begin
                        ld_word = 1'b1;
                    end else begin
                        sh_sh   = 1'b1;
                        cnt_nxt = cnt - 6'd1;
                    end
                end
                ST_WR_DATA: begin
                    sh_sh = 1'b1;
                    if (cnt == 6'd0) begin
                        wr_en_nxt = 1'b1;
                        wdata_nxt = sh_next;
                        cnt_nxt   = xfer_quad ? 6'd7 : 6'd31;
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                    end
                end
                ST_IGNORE: ;
                default:   state_nxt = ST_CMD;
            endcase
        end

        if (ld_word) begin
            sh_ld     = 1'b1;
            rd_en_nxt = 1'b1;
            addr_nxt  = mem_addr + 32'd4;
            cnt_nxt   = xfer_quad ? 6'd7 : 6'd31;
            oe_nxt    = xfer_quad ? 4'hF : 4'h1;
        end
    end

    always_ff @(posedge sclk or negedge h_rstn) begin
        if (!h_rstn) begin
            state        <= ST_CMD;
            cnt          <= 6'd7;
            xfer_quad    <= 1'b0;
            xfer_wr      <= 1'b0;
            addr_4b_mode <= ADDR4B_RST;
            oe_reg       <= 4'h0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            cmd_err      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rd_buf       <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            xfer_quad    <= xfer_quad_nxt;
            xfer_wr      <= xfer_wr_nxt;
            addr_4b_mode <= mode_nxt;
            oe_reg       <= oe_nxt;
            mem_rd_en    <= rd_en_nxt;
            mem_wr_en    <= wr_en_nxt;
            cmd_err      <= err_nxt;
            mem_addr     <= addr_nxt;
            mem_wdata    <= wdata_nxt;
            if (mem_rd_en) rd_buf <= mem_rdata;
        end
    end

    assign io_oe  = oe_reg & {4{~cs_n}};
    assign io_out = oe_reg & (xfer_quad ? sh_msn : {3'b000, sh_msn[3]});
    assign busy   = (state != ST_CMD);

endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable QSPI flash-side responder: decodes command, address and dummy phases on io0..io3 and serves read/program data from a word-wide memory port. It is the target end of the QSPI link, used as the on-bench and FPGA-prototype flash model for the AHB QSPI controller. It is clocked directly by the controller's sclk. IO tri-state resolution is done by the instantiating top from io_out/io_oe.

## Interface
- DUMMY_CYCLES, 4, dummy sclk cycles between address and data for quad reads (≥1)
- ADDR4B_RST, 0, reset value of addr_4b_mode
- sclk  in  1  QSPI clock; all state on rising edge
- h_rstn  in  1  reset, asynchronous, active-low
- cs_n  in  1  chip select, active-low
- io_in  in  4  sampled io3..io0 pins
- io_out  out  4  values driven on io3..io0
- io_oe  out  4  per-line output enable
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_rd_en  out  1  read strobe; mem_rdata valid at next sclk edge
- mem_rdata  in  32  read word
- mem_wr_en  out  1  one-cycle write strobe
- mem_wdata  out  32  assembled program word
- addr_4b_mode  out  1  current address-length mode
- busy  out  1  transaction in progress (state ≠ CMD)
- cmd_err  out  1  one-cycle pulse on unsupported opcode

## Operation
- Commands, MSB first on io0:
  - 0x03 single read; address length per mode.
  - 0x13 single read; 4-byte address.
  - 0xEB quad read; address length per mode.
  - 0xEC quad read; 4-byte address.
  - 0x02 single program; 0x32 quad program; both address length per mode.
  - 0xB7 sets addr_4b_mode; 0xE9 clears it. Mode change takes effect on the 8th command edge.
- Address: single lines (0x03/0x13/0x02/0x32) take 24/32 cycles on io0. Quad reads take 6/8 cycles, nibble per edge, io3=MSB. Low 2 bits are ignored.
- FSM states: CMD → ADDR → (DUMMY) → RD_DATA | WR_DATA. Mode/unknown opcodes go to IGNORE. Every state returns to CMD on any edge with cs_n=1.
- Unknown opcode: cmd_err pulses, state → IGNORE, io_oe stays 0 until cs_n high.
- Read data: 32-bit words MSB first.
  - Single reads drive io0 only. This matches the controller's 1-line sample path.
  - Quad reads drive io3..io0, 8 cycles per word.
  - Prefetch: mem_rd_en for addr+4 is issued on the edge the current word loads. The word loads into the output shifter on the edge after its last bit.
  - Address increments by 4 per word, wrapping modulo 2^32. Reads continue until cs_n rises.
- Program data: words assembled MSB first (io0 or io3..io0). Each complete word → mem_wr_en=1 for one cycle with mem_wdata, mem_addr. Then address +4. A partial word at cs_n rise is discarded.
- io_oe = oe_reg & {4{~cs_n}}, gated combinationally so lines release immediately on deselect. oe_reg is set only in RD_DATA (0001 single, 1111 quad).
- Reset: all outputs 0 except addr_4b_mode=ADDR4B_RST. FSM in CMD. Reset mid-transaction aborts without a memory write.

## Timing
- Edge k captures the last address bit. mem_rd_en=1 and mem_addr are valid after edge k.
- Single read: one turnaround cycle. The shifter loads mem_rdata at edge k+1, and the first data bit is valid after k+1 for master sampling at k+2.
- Quad read: DUMMY_CYCLES edges follow edge k. The first nibble is driven after edge k+DUMMY_CYCLES; mem_rdata is captured by then.
- Output bits change only after rising edges; the master samples on the following rising edge.
- Program: mem_wr_en is asserted after the edge capturing the 32nd bit / 8th nibble.
- cs_n high and data edge simultaneous: cs_n wins. No write, no shift.
- Back-to-back transactions need at least one sclk edge with cs_n high.

## Structure
- Package qspi_pkg holds:
  - opcode localparams: CMD_READ3B=0x03, CMD_READ4B=0x13, CMD_QREAD3B=0xEB, CMD_QREAD4B=0xEC, CMD_PP=0x02, CMD_QPP=0x32, CMD_EN4B=0xB7, CMD_EX4B=0xE9
  - the FSM state enum.
- One sub-module, qspi_resp_shifter: a 32-bit load/shift/assemble register with 1-/4-line width select. It is used for both read output and write assembly.
- A 6-bit phase counter lives in the top module.

## Test plan
- 0x03, addr 0x000010, mem[0x10]=0xA5A5_1234 → mem_rd_en with mem_addr=0x10; io0 drives 32 bits 0xA5A51234 starting the 2nd cycle after the last address bit.
- 0xB7 then 0xEB, addr 0x00000100, 4 dummy cycles, 16 data cycles, mem[0x100]=0x0123_4567, mem[0x104]=0x89AB_CDEF → addr_4b_mode=1; nibbles 0,1,…,F on io3..io0; io_oe=1111 only during data.
- 0x32, 3-byte addr 0x000040, nibbles 0xDEADBEEF then 0xCAFEF00D → two mem_wr_en pulses at 0x40 and 0x44 with those words.
- 0x02 with cs_n rising after 20 data bits → no mem_wr_en; busy=0, io_oe=0 after next edge.
- Opcode 0x9F → cmd_err one cycle; io_oe stays 0000 until cs_n high; next 0x03 works normally.
- h_rstn low mid quad read → all outputs 0, addr_4b_mode=ADDR4B_RST, FSM in CMD.
